alu_seq: RTL and testbench

//  Parametrised, registered successor of the 16-bit combinational ALU: same opcode map plus NOR,

---
 rtl/alu_seq.sv | 146 ++++++++++++++
 tb/tb_alu_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides and a fixed-latency
// shift-add multiplier; one operation in flight at a time.
//
// state | meaning
// IDLE  | ready for a new operation (in_ready=1)
// MUL   | shift-add multiply in progress, WIDTH iterations
// DONE  | result/flags held until the consumer takes them
module alu_seq #(
    parameter int WIDTH  = 16,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  source1,
    input  logic [WIDTH-1:0]  source2,
    input  logic [CTRL_W-1:0] ALU_CTRL,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              ovf,
    output logic              illegal
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(4'b1000);
    localparam logic [CTRL_W-1:0] OP_MUL  = CTRL_W'(4'b1001);
    localparam logic [CTRL_W-1:0] OP_NOR  = CTRL_W'(4'b1100);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [WIDTH-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic               alu_ill;
    logic               is_mul;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   acc_next;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        is_mul  = 1'b0;
        sum     = source1 + source2;
        diff    = source1 - source2;
        case (ALU_CTRL)
            OP_AND:  alu_res = source1 & source2;
            OP_OR:   alu_res = source1 | source2;
            OP_NOR:  alu_res = ~(source1 | source2);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (source1[WIDTH-1] == source2[WIDTH-1]) &&
                          (sum[WIDTH-1] != source1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (source1[WIDTH-1] != source2[WIDTH-1]) &&
                          (diff[WIDTH-1] != source1[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(source1) < $signed(source2))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (source1 < source2)};
            OP_MUL:  is_mul  = 1'b1;
            default: alu_ill = 1'b1;
        endcase
    end

    // The last iteration's partial sum is written straight to result, so the
    // multiply occupies exactly WIDTH cycles in MUL after the accept edge.
    assign acc_next = acc + (mul_b[0] ? mul_a : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (is_mul) begin
                            mul_a <= source1;
                            mul_b <= source2;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= MUL;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            ovf       <= alu_ovf;
                            illegal   <= alu_ill;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc   <= acc_next;
                    mul_a <= mul_a << 1;
                    mul_b <= mul_b >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH-1)) begin
                        result    <= acc_next;
                        zero      <= (acc_next == '0);
                        ovf       <= 1'b0;
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq (WIDTH=16): opcode vectors with
// hand-computed results, plus multiply, backpressure and reset sequences.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] source1;
    logic [15:0] source2;
    logic [3:0]  ALU_CTRL;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        zero;
    logic        ovf;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq #(.WIDTH(16), .CTRL_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .source1(source1), .source2(source2), .ALU_CTRL(ALU_CTRL),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .ovf(ovf), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic [15:0] res;
        logic        z;
        logic        o;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_result"},    32'(result),    32'd0);
        check({tag, "_zero"},      32'(zero),      32'd0);
        check({tag, "_ovf"},       32'(ovf),       32'd0);
        check({tag, "_illegal"},   32'(illegal),   32'd0);
    endtask

    // Present an operation and hold it until the accepting edge; returns #1 after it.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("issue_ready_timeout", 32'(in_ready), 32'd1);
        source1  = a;
        source2  = b;
        ALU_CTRL = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        source1  = 16'hDEAD;
        source2  = 16'hBEEF;
        ALU_CTRL = 4'b0000;
    endtask

    // lat = number of rising edges from the accept edge (counted as 1) until out_valid.
    task automatic wait_result(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic consume(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({name, "_drop_valid"}, 32'(out_valid), 32'd0);
        check({name, "_ready_back"}, 32'(in_ready),  32'd1);
    endtask

    task automatic do_op(input vec_t v);
        int lat;
        issue(v.a, v.b, v.op);
        wait_result(lat);
        check({v.name, "_latency"}, 32'(lat),     32'(v.lat));
        check({v.name, "_result"},  32'(result),  32'(v.res));
        check({v.name, "_zero"},    32'(zero),    32'(v.z));
        check({v.name, "_ovf"},     32'(ovf),     32'(v.o));
        check({v.name, "_illegal"}, 32'(illegal), 32'(v.ill));
        consume(v.name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vec_t v;

        //          name      a         b         op       res      z     o     ill   lat
        vecs[0]  = '{"and",   16'hF0F0, 16'h0FF0, 4'b0000, 16'h00F0, 1'b0, 1'b0, 1'b0, 1};
        vecs[1]  = '{"or",    16'hF0F0, 16'h0FF0, 4'b0001, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1};
        vecs[2]  = '{"nor",   16'hF0F0, 16'h0FF0, 4'b1100, 16'h000F, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{"addov", 16'h7FFF, 16'h0001, 4'b0010, 16'h8000, 1'b0, 1'b1, 1'b0, 1};
        vecs[4]  = '{"subz",  16'h1234, 16'h1234, 4'b0110, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[5]  = '{"subov", 16'h8000, 16'h0001, 4'b0110, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1};
        vecs[6]  = '{"addwr", 16'hFFFF, 16'h0001, 4'b0010, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[7]  = '{"slt1",  16'hFFFF, 16'h0001, 4'b0111, 16'h0001, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{"sltu0", 16'hFFFF, 16'h0001, 4'b1000, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[9]  = '{"slt0",  16'h0001, 16'hFFFF, 4'b0111, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[10] = '{"sltu1", 16'h0001, 16'hFFFF, 4'b1000, 16'h0001, 1'b0, 1'b0, 1'b0, 1};
        vecs[11] = '{"illeg", 16'h1234, 16'h5678, 4'b0011, 16'h0000, 1'b1, 1'b0, 1'b1, 1};
        vecs[12] = '{"mul1",  16'h0123, 16'h0045, 4'b1001, 16'h4E6F, 1'b0, 1'b0, 1'b0, 17};
        vecs[13] = '{"mulff", 16'hFFFF, 16'hFFFF, 4'b1001, 16'h0001, 1'b0, 1'b0, 1'b0, 17};
        vecs[14] = '{"mul0",  16'h0000, 16'h0005, 4'b1001, 16'h0000, 1'b1, 1'b0, 1'b0, 17};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        source1   = '0;
        source2   = '0;
        ALU_CTRL  = '0;
        #3;
        check_reset("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) do_op(vecs[i]);

        // in_valid pulsed during MUL is ignored; operands are latched at accept.
        issue(16'h0003, 16'h0005, 4'b1001);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mulbusy_in_ready", 32'(in_ready), 32'd0);
        source1  = 16'hFFFF;
        source2  = 16'hFFFF;
        ALU_CTRL = 4'b0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(lat);
        check("mulbusy_latency", 32'(lat),    32'd12);
        check("mulbusy_result",  32'(result), 32'h000F);
        consume("mulbusy");
        repeat (3) @(negedge clk);
        check("mulbusy_no_extra", 32'(out_valid), 32'd0);

        // Backpressure: result and flags held while out_ready is low.
        issue(16'h0005, 16'h0003, 4'b0010);
        wait_result(lat);
        check("bp_latency", 32'(lat), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_result",   32'(result),    32'h0008);
            check("bp_flags",    32'({zero, ovf, illegal}), 32'd0);
            check("bp_in_ready", 32'(in_ready),  32'd0);
        end
        consume("bp");

        // Asynchronous reset eight cycles into a multiply.
        issue(16'h0123, 16'h0045, 4'b1001);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("rstmul_busy", 32'(in_ready), 32'd0);
        check("rstmul_prev_result", 32'(result), 32'h0008);
        rst = 1'b1;
        #1;
        check_reset("rstmul");
        @(negedge clk);
        rst = 1'b0;
        v = '{"postrst", 16'h0002, 16'h0003, 4'b0010, 16'h0005, 1'b0, 1'b0, 1'b0, 1};
        do_op(v);
        v = '{"postmul", 16'h0010, 16'h0011, 4'b1001, 16'h0110, 1'b0, 1'b0, 1'b0, 17};
        do_op(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
